// File: rtl/pe_load_sequencer_pkg.sv
// Shared definitions for the PE load sequencer: controlSignal codes that the
// LocalStoreController also decodes, plus the sequencer FSM state type.
package pe_load_sequencer_pkg;

   localparam int CTRL_W = 6;

   localparam logic [CTRL_W-1:0] CTRL_IDLE     = 6'd0;
   localparam logic [CTRL_W-1:0] CTRL_ADDR_CLR = 6'd1;
   localparam logic [CTRL_W-1:0] CTRL_INC_K    = 6'd2;
   localparam logic [CTRL_W-1:0] CTRL_INC_N    = 6'd3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CLR    = 2'd1,
      STREAM = 2'd2,
      FIN    = 2'd3
   } state_e;

endpackage

// File: rtl/pe_load_sequencer.sv
// Streams a command's words into one PE column (kernel) or row (neuron) store.
// Define PE_LOAD_SEQUENCER_BROADCAST_EN to make index all-ones hit every column/row.
module pe_load_sequencer
   import pe_load_sequencer_pkg::*;
#(
   parameter  int DEPTH = 2,
   parameter  int A     = 7,
   parameter  int W     = 16,
   parameter  int ROWS  = 4,
   parameter  int COLS  = 4,
   localparam int IW    = $clog2((ROWS > COLS) ? ROWS : COLS) + 1
) (
   input  logic                     CLK,
   input  logic                     RESETn,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic                     cmd_target,
   input  logic [IW-1:0]            cmd_index,
   input  logic [A:0]               cmd_len,
   input  logic                     data_valid,
   output logic                     data_ready,
   input  logic [W-1:0]             data_in,
   output logic [W-1:0]             kernel_out,
   output logic [W-1:0]             neuron_out,
   output logic [7*COLS-1:0]        column_control,
   output logic [(DEPTH+1)*ROWS-1:0] row_control,
   output logic                     busy,
   output logic                     done,
   output logic                     err
);

   state_e               state_q, state_d;
   logic                 tgt_q, tgt_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic [A:0]           len_q, len_d;
   logic [A:0]           cnt_q, cnt_d;
   logic                 cmd_ready_q, cmd_ready_d;
   logic                 data_ready_q, data_ready_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;
   logic [W-1:0]         kout_q, kout_d;
   logic [W-1:0]         nout_q, nout_d;
   logic [CTRL_W-1:0]    ctrl_q, ctrl_d;
   logic [COLS-1:0]      kwr_q, kwr_d;
   logic [ROWS-1:0]      nwr_q, nwr_d;
   logic [DEPTH-1:0]     init_q, init_d;
   logic [DEPTH+IW-1:0]  idx_wide;
   logic                 lim_ok, bcast_cmd, bcast_cur, legal;

   always_comb begin
      lim_ok = cmd_target ? (cmd_index < IW'(ROWS)) : (cmd_index < IW'(COLS));
`ifdef PE_LOAD_SEQUENCER_BROADCAST_EN
      bcast_cmd = &cmd_index;
      bcast_cur = &idx_q;
`else
      bcast_cmd = 1'b0;
      bcast_cur = 1'b0;
`endif
      legal = (cmd_len != '0) && (lim_ok || bcast_cmd);
   end

   always_comb begin
      state_d      = state_q;
      tgt_d        = tgt_q;
      idx_d        = idx_q;
      len_d        = len_q;
      cnt_d        = cnt_q;
      cmd_ready_d  = 1'b0;
      data_ready_d = 1'b0;
      done_d       = 1'b0;
      err_d        = 1'b0;
      kout_d       = kout_q;
      nout_d       = nout_q;
      ctrl_d       = CTRL_IDLE;
      kwr_d        = '0;
      nwr_d        = '0;
      case (state_q)
         IDLE: begin
            cmd_ready_d = 1'b1;
            if (cmd_valid && cmd_ready_q) begin
               if (legal) begin
                  tgt_d       = cmd_target;
                  idx_d       = cmd_index;
                  len_d       = cmd_len;
                  cnt_d       = '0;
                  cmd_ready_d = 1'b0;
                  ctrl_d      = CTRL_ADDR_CLR;
                  state_d     = CLR;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         CLR: begin
            data_ready_d = 1'b1;
            state_d      = STREAM;
         end
         STREAM: begin
            data_ready_d = 1'b1;
            if (data_valid) begin
               // accepted beat is presented with its strobe on the next cycle
               if (tgt_q) begin
                  nout_d = data_in;
                  ctrl_d = CTRL_INC_N;
                  for (int r = 0; r < ROWS; r++) nwr_d[r] = bcast_cur | (idx_q == IW'(r));
               end else begin
                  kout_d = data_in;
                  ctrl_d = CTRL_INC_K;
                  for (int c = 0; c < COLS; c++) kwr_d[c] = bcast_cur | (idx_q == IW'(c));
               end
               cnt_d = cnt_q + (A+1)'(1);
               if (cnt_d == len_q) begin
                  data_ready_d = 1'b0;
                  state_d      = FIN;
               end
            end
         end
         FIN: begin
            done_d      = 1'b1;
            cmd_ready_d = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d   = (state_d != IDLE);
      idx_wide = {{DEPTH{1'b0}}, idx_d};
      init_d   = busy_d ? idx_wide[DEPTH-1:0] : '0;
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state_q      <= IDLE;
         tgt_q        <= 1'b0;
         idx_q        <= '0;
         len_q        <= '0;
         cnt_q        <= '0;
         cmd_ready_q  <= 1'b1;
         data_ready_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         kout_q       <= '0;
         nout_q       <= '0;
         ctrl_q       <= CTRL_IDLE;
         kwr_q        <= '0;
         nwr_q        <= '0;
         init_q       <= '0;
      end else begin
         state_q      <= state_d;
         tgt_q        <= tgt_d;
         idx_q        <= idx_d;
         len_q        <= len_d;
         cnt_q        <= cnt_d;
         cmd_ready_q  <= cmd_ready_d;
         data_ready_q <= data_ready_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
         kout_q       <= kout_d;
         nout_q       <= nout_d;
         ctrl_q       <= ctrl_d;
         kwr_q        <= kwr_d;
         nwr_q        <= nwr_d;
         init_q       <= init_d;
      end
   end

   for (genvar c = 0; c < COLS; c++) begin : g_col
      assign column_control[7*c +: 7] = {ctrl_q, kwr_q[c]};
   end
   for (genvar r = 0; r < ROWS; r++) begin : g_row
      assign row_control[(DEPTH+1)*r +: DEPTH+1] = {init_q, nwr_q[r]};
   end

   assign cmd_ready  = cmd_ready_q;
   assign data_ready = data_ready_q;
   assign kernel_out = kout_q;
   assign neuron_out = nout_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_pe_load_sequencer.sv
// Directed bench for pe_load_sequencer; expectations are hand-derived cycle by cycle.
module tb_pe_load_sequencer;
   import pe_load_sequencer_pkg::*;

   localparam int DEPTH = 2;
   localparam int A     = 7;
   localparam int W     = 16;
   localparam int ROWS  = 4;
   localparam int COLS  = 4;
   localparam int IW    = 3;

   logic                      CLK = 1'b0;
   logic                      RESETn = 1'b0;
   logic                      cmd_valid = 1'b0;
   logic                      cmd_ready;
   logic                      cmd_target = 1'b0;
   logic [IW-1:0]             cmd_index = '0;
   logic [A:0]                cmd_len = '0;
   logic                      data_valid = 1'b0;
   logic                      data_ready;
   logic [W-1:0]              data_in = '0;
   logic [W-1:0]              kernel_out;
   logic [W-1:0]              neuron_out;
   logic [7*COLS-1:0]         column_control;
   logic [(DEPTH+1)*ROWS-1:0] row_control;
   logic                      busy, done, err;

   pe_load_sequencer #(.DEPTH(DEPTH), .A(A), .W(W), .ROWS(ROWS), .COLS(COLS)) dut (
      .CLK(CLK), .RESETn(RESETn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_target(cmd_target),
      .cmd_index(cmd_index), .cmd_len(cmd_len),
      .data_valid(data_valid), .data_ready(data_ready), .data_in(data_in),
      .kernel_out(kernel_out), .neuron_out(neuron_out),
      .column_control(column_control), .row_control(row_control),
      .busy(busy), .done(done), .err(err)
   );

   always #5 CLK = ~CLK;

   int n_chk  = 0;
   int n_fail = 0;
   int good, bad, dn, first, last;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic send_cmd(input logic t, input logic [IW-1:0] i, input logic [A:0] l);
      cmd_valid  = 1'b1;
      cmd_target = t;
      cmd_index  = i;
      cmd_len    = l;
      step();
      cmd_valid  = 1'b0;
   endtask

   function automatic logic [7*COLS-1:0] colctl(input logic [5:0] c, input logic [COLS-1:0] m);
      logic [7*COLS-1:0] v;
      for (int i = 0; i < COLS; i++) v[7*i +: 7] = {c, m[i]};
      return v;
   endfunction

   function automatic logic [(DEPTH+1)*ROWS-1:0] rowctl(input logic [DEPTH-1:0] s, input logic [ROWS-1:0] m);
      logic [(DEPTH+1)*ROWS-1:0] v;
      for (int i = 0; i < ROWS; i++) v[(DEPTH+1)*i +: DEPTH+1] = {s, m[i]};
      return v;
   endfunction

   initial begin
      // reset state
      #2;
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_drdy", 32'(data_ready), 32'(0));
      chk("rst_col", 32'(column_control), 32'(0));
      chk("rst_row", 32'(row_control), 32'(0));
      chk("rst_done_err", 32'({done, err}), 32'(0));
      step(); step();
      RESETn = 1'b1;
      step();
      chk("rst_crdy", 32'(cmd_ready), 32'(1));

      // kernel column 2, three continuous words
      send_cmd(1'b0, 3'd2, 8'd3);
      chk("s1_clr_col", 32'(column_control), 32'(colctl(CTRL_ADDR_CLR, 4'b0000)));
      chk("s1_clr_busy", 32'(busy), 32'(1));
      chk("s1_clr_crdy", 32'(cmd_ready), 32'(0));
      chk("s1_clr_row", 32'(row_control), 32'(rowctl(2'd2, 4'b0000)));
      data_valid = 1'b1; data_in = 16'h0011;
      step();
      chk("s1_drdy", 32'(data_ready), 32'(1));
      chk("s1_pre_col", 32'(column_control), 32'(colctl(CTRL_IDLE, 4'b0000)));
      step();
      chk("s1_b0_col", 32'(column_control), 32'(colctl(CTRL_INC_K, 4'b0100)));
      chk("s1_b0_data", 32'(kernel_out), 32'h11);
      data_in = 16'h0022;
      step();
      chk("s1_b1_col", 32'(column_control), 32'(colctl(CTRL_INC_K, 4'b0100)));
      chk("s1_b1_data", 32'(kernel_out), 32'h22);
      data_in = 16'h0033;
      step();
      data_valid = 1'b0;
      chk("s1_b2_col", 32'(column_control), 32'(colctl(CTRL_INC_K, 4'b0100)));
      chk("s1_b2_data", 32'(kernel_out), 32'h33);
      chk("s1_b2_drdy_done", 32'({data_ready, done, busy}), 32'(3'b001));
      step();
      chk("s1_fin", 32'({done, busy, cmd_ready}), 32'(3'b101));
      chk("s1_fin_col", 32'(column_control), 32'(0));
      chk("s1_fin_row", 32'(row_control), 32'(0));
      step();
      chk("s1_done_pulse", 32'(done), 32'(0));

      // neuron row 1, two words with a two-cycle gap
      send_cmd(1'b1, 3'd1, 8'd2);
      chk("s2_clr_col", 32'(column_control), 32'(colctl(CTRL_ADDR_CLR, 4'b0000)));
      data_valid = 1'b1; data_in = 16'hA5A5;
      step();
      step();
      chk("s2_b0_row", 32'(row_control), 32'(rowctl(2'd1, 4'b0010)));
      chk("s2_b0_col", 32'(column_control), 32'(colctl(CTRL_INC_N, 4'b0000)));
      chk("s2_b0_data", 32'(neuron_out), 32'hA5A5);
      data_valid = 1'b0;
      for (int g = 0; g < 2; g++) begin
         step();
         chk("s2_gap_row", 32'(row_control), 32'(rowctl(2'd1, 4'b0000)));
         chk("s2_gap_col", 32'(column_control), 32'(colctl(CTRL_IDLE, 4'b0000)));
      end
      data_valid = 1'b1; data_in = 16'h5A5A;
      step();
      data_valid = 1'b0;
      chk("s2_b1_row", 32'(row_control), 32'(rowctl(2'd1, 4'b0010)));
      chk("s2_b1_data", 32'(neuron_out), 32'h5A5A);
      step();
      chk("s2_done", 32'({done, busy}), 32'(2'b10));

      // illegal commands
      send_cmd(1'b0, 3'd4, 8'd3);
      chk("s3_idx_err", 32'({err, busy, cmd_ready}), 32'(3'b101));
      chk("s3_idx_col", 32'(column_control), 32'(0));
      step();
      chk("s3_idx_errpulse", 32'({err, busy}), 32'(0));
      send_cmd(1'b1, 3'd1, 8'd0);
      chk("s3_len_err", 32'({err, busy}), 32'(2'b10));
      chk("s3_len_row", 32'(row_control), 32'(0));
      step();
      chk("s3_len_errpulse", 32'(err), 32'(0));

      // reset during second beat of a five-word load
      send_cmd(1'b0, 3'd3, 8'd5);
      data_valid = 1'b1; data_in = 16'h1234;
      step(); step(); step();
      chk("s4_b1_col", 32'(column_control), 32'(colctl(CTRL_INC_K, 4'b1000)));
      #1 RESETn = 1'b0;
      #1;
      chk("s4_rst_col", 32'(column_control), 32'(0));
      chk("s4_rst_row", 32'(row_control), 32'(0));
      chk("s4_rst_flags", 32'({busy, done, err, data_ready}), 32'(0));
      chk("s4_rst_data", 32'(kernel_out), 32'(0));
      data_valid = 1'b0;
      #4 RESETn = 1'b1;
      step();
      chk("s4_rel", 32'({cmd_ready, busy}), 32'(2'b10));
      send_cmd(1'b0, 3'd0, 8'd1);
      data_valid = 1'b1; data_in = 16'hBEEF;
      step(); step();
      data_valid = 1'b0;
      chk("s4_new_col", 32'(column_control), 32'(colctl(CTRL_INC_K, 4'b0001)));
      chk("s4_new_data", 32'(kernel_out), 32'hBEEF);
      step();
      chk("s4_new_done", 32'({done, busy}), 32'(2'b10));

      // full-depth load of 2^A words
      send_cmd(1'b0, 3'd1, 8'd128);
      data_valid = 1'b1;
      good = 0; bad = 0; dn = 0; first = -1; last = -1;
      for (int k = 0; k < 140; k++) begin
         data_in = 16'(k);
         step();
         if (column_control[7]) begin
            good++;
            if (first < 0) first = k;
            last = k;
         end
         if ((column_control & 28'h0204001) != '0) bad++;
         if (done) dn++;
      end
      data_valid = 1'b0;
      chk("s5_strobes", 32'(good), 32'(128));
      chk("s5_other_strobes", 32'(bad), 32'(0));
      chk("s5_done_cnt", 32'(dn), 32'(1));
      chk("s5_span", 32'(last - first), 32'(127));
      chk("s5_idle", 32'({busy, cmd_ready}), 32'(2'b01));

      // neuron index all-ones
      send_cmd(1'b1, 3'd7, 8'd1);
`ifdef PE_LOAD_SEQUENCER_BROADCAST_EN
      chk("s6_bc_busy", 32'({busy, err}), 32'(2'b10));
      data_valid = 1'b1; data_in = 16'h00C3;
      step(); step();
      data_valid = 1'b0;
      chk("s6_bc_row", 32'(row_control), 32'(rowctl(2'd3, 4'b1111)));
      step();
      chk("s6_bc_done", 32'(done), 32'(1));
`else
      chk("s6_nobc_err", 32'({err, busy}), 32'(2'b10));
      chk("s6_nobc_row", 32'(row_control), 32'(0));
      step();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/pe_load_sequencer.md
PE_LOAD_SEQUENCER -- requirements
Module: pe_load_sequencer

Interface
REQ-001 SHALL have parameters: DEPTH, default 2, LocalStoreController depth; A, default 7, local-store address width; W, default 16, data width; ROWS, default 4, PE rows; COLS, default 4, PE columns.
REQ-002 SHALL have one clock and an asynchronous, active-low reset; ports:
- CLK  in  1  clock.
- RESETn  in  1  async active-low reset.
- cmd_valid  in  1  load command offered.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_target  in  1  0 = kernel stores, 1 = neuron stores.
- cmd_index  in  IW  column (kernel) or row (neuron) index; IW = $clog2(max(ROWS,COLS))+1.
- cmd_len  in  A+1  words to write, legal range 1..2^A.
- data_valid  in  1  data beat offered.
- data_ready  out  1  beat accepted when high with data_valid.
- data_in  in  W  beat payload.
- kernel_out  out  W  to every PE kernelIn.
- neuron_out  out  W  to every PE neuronIn.
- column_control  out  7*COLS  per column {controlSignal[5:0], kernelWrite}, column c at [7c+6:7c].
- row_control  out  (DEPTH+1)*ROWS  per row {initSettings, neuronWrite}.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse at command completion.
- err  out  1  one-cycle pulse on rejected command.

Function
REQ-003 SHALL register all outputs.
REQ-004 SHALL implement the FSM states IDLE, CLR, STREAM, FIN.
REQ-005 In IDLE, cmd_ready SHALL be 1; on cmd_valid&cmd_ready the block SHALL latch target, index and len.
REQ-006 The block SHALL reject a command with cmd_len==0 or index >= COLS (kernel) / ROWS (neuron): err=1 for one cycle, state stays IDLE.
REQ-007 For a legal command, the next state SHALL be CLR; CLR SHALL drive controlSignal=CTRL_ADDR_CLR on all columns for exactly one cycle, then go to STREAM.
REQ-008 In STREAM, data_ready SHALL be 1; each accepted beat SHALL, in the following cycle, present data_in on kernel_out/neuron_out and assert exactly one write strobe.
- Kernel target: kernelWrite of column index.
- Neuron target: neuronWrite of row index.
- Controls on every column in that cycle: CTRL_INC_K (kernel) or CTRL_INC_N (neuron).
REQ-009 In any cycle without a presented beat, every write strobe SHALL be 0 and controlSignal SHALL be CTRL_IDLE; the beat counter SHALL hold.
REQ-010 After the cmd_len-th beat, data_ready SHALL drop and the next state SHALL be FIN; FIN SHALL pulse done for one cycle and return to IDLE.
REQ-011 initSettings SHALL be driven to the latched index's low DEPTH bits on all rows while busy, and 0 otherwise.
REQ-012 busy SHALL be 1 in CLR, STREAM and FIN.
REQ-013 cmd_ready SHALL be 0 and data_ready SHALL be 0 outside IDLE and STREAM respectively.
REQ-014 cmd_len=2^A SHALL write all addresses exactly once; the counter SHALL NOT wrap.
REQ-015 Throughput SHALL be one word per cycle with data_valid held high.

Reset
REQ-016 RESETn low SHALL asynchronously force IDLE, clear the counter, and zero every output except cmd_ready, which SHALL be 1 after reset release; this applies mid-command, and the partial load is abandoned.

Configuration
REQ-017 When PE_LOAD_SEQUENCER_BROADCAST_EN is defined, cmd_index all-ones SHALL be legal and SHALL assert the strobe on every column (kernel) or every row (neuron) per beat.
REQ-018 When PE_LOAD_SEQUENCER_BROADCAST_EN is undefined, cmd_index all-ones SHALL be rejected per REQ-006.

Structure
REQ-019 A shared package SHALL hold the controlSignal codes CTRL_IDLE=6'd0, CTRL_ADDR_CLR=6'd1, CTRL_INC_K=6'd2 and CTRL_INC_N=6'd3, plus the FSM state typedef; LocalStoreController SHALL decode the same codes.
REQ-020 The FSM and the strobe decoder SHALL live in one module; a sub-module SHALL NOT be required.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Kernel, index 2, len 3, data 0x11/0x22/0x33 continuous: one CLR cycle, then three cycles of kernelWrite col2 only with CTRL_INC_K and kernel_out 0x11, 0x22, 0x33; done one cycle later.
- Neuron, index 1, len 2, data_valid low for 2 cycles between beats: gap cycles show no strobe and CTRL_IDLE; both words are delivered.
- Kernel, index 4 (COLS=4), or len 0: err pulse, busy stays 0, no strobes.
- RESETn low during the 2nd beat of len 5: all outputs 0 immediately; after release, a new len-1 command completes normally.
- len 128 (A=7): exactly 128 strobes and one done.
- Broadcast enabled, neuron, index all-ones, len 1: neuronWrite high on all 4 rows for one cycle; broadcast disabled: err pulse.
